avl_mem_responder: RTL and testbench
====================================

# avl_mem_responder

Avalon-MM slave endpoint backing a local word-addressed memory. It terminates the master side of the conv accelerator's memory export bridge, so bridged transactions can be checked and exercised without external DDR. It accepts chipselect/write requests, drives a registered waitrequest handshake, commits byte-enabled writes and returns read data after a configurable latency.

## Interface
Parameters:
- ADDR_WIDTH, 64, byte address width
- DATA_WIDTH, 64, data bus width; power of two, ≥ 8
- BE_WIDTH, 8, byte enables; equals DATA_WIDTH/8
- DEPTH, 1024, memory words; power of two
- READ_LATENCY, 2, cycles from request sample to read acknowledge; ≥ 1

Ports:
- clk  input  1  sole clock
- reset  input  1  asynchronous, active-high reset
- avl_slave_chipselect  input  1  request valid
- avl_slave_addr  input  ADDR_WIDTH  byte address; word index = addr >> log2(BE_WIDTH)
- avl_slave_rdata  output  DATA_WIDTH  read data, registered
- avl_slave_wdata  input  DATA_WIDTH  write data
- avl_slave_be  input  BE_WIDTH  byte enables, write only
- avl_slave_write_req  input  1  1 = write, 0 = read (while chipselect is high)
- avl_slave_waitrequest  output  1  registered; a transfer completes on a cycle with chipselect=1 and waitrequest=0
- range_err  output  1  sticky out-of-range flag; present only with AVL_RESP_RANGE_CHECK_EN

## Operation
- States: IDLE, WACK, RWAIT, RACK.
- IDLE: waitrequest=1. chipselect=1 and write_req=1 -> WACK. chipselect=1 and write_req=0 -> RWAIT, or RACK directly if READ_LATENCY=1. Read counter loads READ_LATENCY-1.
- WACK: waitrequest=0. If chipselect is still 1, the write commits to memory this cycle. Each byte lane i is updated only where be[i]=1; be=0 is acknowledged with no change. Next state: IDLE.
- RWAIT: memory read issues on entry. Counter decrements each cycle; at 1 -> RACK.
- RACK: rdata is loaded on entry. waitrequest=0 for exactly one cycle. Next state: IDLE.
- rdata holds its value until the next read acknowledge; writes never change it.
- chipselect=0 observed in WACK or RWAIT (master abort): return to IDLE, no memory update, rdata unchanged.
- Request fields are sampled in IDLE only. Changes while waitrequest=1 are ignored; this is the master's protocol obligation.
- Index wrap: only the low log2(DEPTH) word-index bits are used; higher bits alias.

## Timing
- Reset values: waitrequest=1, rdata=0, state=IDLE, range_err=0. Memory contents are not reset.
- Reset asserted mid-transaction: immediate return to IDLE. An in-flight write in WACK is not guaranteed to commit; a pending read is dropped.
- Write: request seen in IDLE at cycle N; ack (waitrequest=0) at N+1; next request is sampled no earlier than N+2.
- Read: request seen at N; ack with valid rdata at N+READ_LATENCY.
- Throughput: one transfer per 2 cycles for writes, one per READ_LATENCY+1 cycles for reads.
- Write then read to the same address back-to-back returns the new data (no read-during-write hazard, since the write commits before the read issues).

## Configuration
- AVL_RESP_RANGE_CHECK_EN defined:
  - Word index ≥ DEPTH (full address, ignoring byte offset) is out of range.
  - Out-of-range writes are acknowledged and dropped.
  - Out-of-range reads are acknowledged with rdata all-ones.
  - range_err sets and stays set until reset.
- Not defined: no range_err port; aliasing as in Operation.

## Structure
- Package avl_resp_pkg:
  - state enum (IDLE/WACK/RWAIT/RACK)
  - function clog2
  - constant RANGE_ERR_DATA = all-ones
- Sub-module avl_resp_ram: single-port, byte-enabled, synchronous read, 1-cycle read latency, DEPTH×DATA_WIDTH. Inferred as block RAM.
- Responder FSM, latency counter and range check sit in avl_mem_responder.

## Test plan
- Write 0x1122334455667788 to addr 0x10 with be=0xFF, then write 0xAAAAAAAABBBBBBBB with be=0x0F. Reading addr 0x10 -> rdata=0x11223344BBBBBBBB.
- With READ_LATENCY=3, a read issued at cycle N -> waitrequest low only at N+3 for one cycle. A write -> ack exactly at N+1.
- Drop chipselect in WACK during a write of 0xFF..FF to addr 0x20 -> state returns to IDLE, and a later read of 0x20 returns the prior contents.
- Assert reset during RWAIT -> waitrequest=1, rdata=0 in the same cycle. After release, a fresh read completes normally.
- DEPTH=1024, write 0xCAFE to byte addr 0x2000 (word 1024):
  - without the macro -> read of addr 0x0 returns 0xCAFE
  - with the macro -> addr 0x0 is unchanged, a read of 0x2000 returns all-ones, and range_err=1 and stays set
- Back-to-back write and read of the same address -> read returns the newly written data. Each transfer spans exactly the cycle counts in Timing.

Source files
------------

// File: rtl/avl_resp_pkg.sv
// Shared types and helpers for the Avalon-MM memory responder.
// Used by avl_resp_ram and avl_mem_responder (optional AVL_RESP_RANGE_CHECK_EN build).
package avl_resp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WACK  = 2'd1,
    RWAIT = 2'd2,
    RACK  = 2'd3
  } resp_state_e;

  localparam int MAX_DATA_WIDTH = 1024;

  // Read data returned for out-of-range reads; sliced to the bus width at use.
  localparam logic [MAX_DATA_WIDTH-1:0] RANGE_ERR_DATA = '1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/avl_resp_ram.sv
// Single-port byte-enabled RAM, synchronous read with one cycle of latency.
// Contents are never reset; only the read data register is.
module avl_resp_ram
  import avl_resp_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int BE_WIDTH   = 8,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  we,
  input  logic [BE_WIDTH-1:0]   be,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/avl_mem_responder.sv
// Avalon-MM slave endpoint over a local word-addressed RAM with registered waitrequest.
// Define AVL_RESP_RANGE_CHECK_EN to reject word indices >= DEPTH and expose range_err.
module avl_mem_responder
  import avl_resp_pkg::*;
#(
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int BE_WIDTH     = 8,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  avl_slave_chipselect,
  input  logic [ADDR_WIDTH-1:0] avl_slave_addr,
  output logic [DATA_WIDTH-1:0] avl_slave_rdata,
  input  logic [DATA_WIDTH-1:0] avl_slave_wdata,
  input  logic [BE_WIDTH-1:0]   avl_slave_be,
  input  logic                  avl_slave_write_req,
  output logic                  avl_slave_waitrequest
`ifdef AVL_RESP_RANGE_CHECK_EN
  ,
  output logic                  range_err
`endif
);

  localparam int OFF_W = clog2(BE_WIDTH);
  localparam int IDX_W = clog2(DEPTH);
  localparam int CNT_W = clog2(READ_LATENCY) + 1;
  localparam logic [DATA_WIDTH-1:0] ERR_DATA = RANGE_ERR_DATA[DATA_WIDTH-1:0];

  resp_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_WIDTH-1:0]   be_q, be_d;
  logic                  wr_oor_q, wr_oor_d;
  logic                  rd_oor_q, rd_oor_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  wait_q, wait_d;

  logic                  ram_we;
  logic                  ram_re;
  logic [IDX_W-1:0]      ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic [IDX_W-1:0]      req_idx;
  logic                  req_oor;
  logic                  unused_addr;

  assign req_idx     = IDX_W'(avl_slave_addr >> OFF_W);
  assign unused_addr = ^avl_slave_addr;

`ifdef AVL_RESP_RANGE_CHECK_EN
  logic range_err_q, range_err_d;
  assign req_oor   = |(avl_slave_addr >> (OFF_W + IDX_W));
  assign range_err = range_err_q;
`else
  assign req_oor = 1'b0;
`endif

  // Valid/ready: a transfer completes on a cycle with chipselect=1 and waitrequest=0.
  // Requests are captured in IDLE only; the RAM read is issued in the same cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    wr_oor_d = wr_oor_q;
    rd_oor_d = rd_oor_q;
    rdata_d  = rdata_q;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = req_idx;
`ifdef AVL_RESP_RANGE_CHECK_EN
    range_err_d = range_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (avl_slave_chipselect) begin
`ifdef AVL_RESP_RANGE_CHECK_EN
          if (req_oor) range_err_d = 1'b1;
`endif
          if (avl_slave_write_req) begin
            idx_d    = req_idx;
            wdata_d  = avl_slave_wdata;
            be_d     = avl_slave_be;
            wr_oor_d = req_oor;
            state_d  = WACK;
          end else begin
            ram_re   = 1'b1;
            rd_oor_d = req_oor;
            cnt_d    = CNT_W'(READ_LATENCY - 1);
            state_d  = (READ_LATENCY == 1) ? RACK : RWAIT;
          end
        end
      end
      WACK: begin
        ram_addr = idx_q;
        if (avl_slave_chipselect && !wr_oor_q) ram_we = 1'b1;
        state_d = IDLE;
      end
      RWAIT: begin
        if (!avl_slave_chipselect) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          rdata_d = rd_oor_q ? ERR_DATA : ram_rdata;
          state_d = RACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    wait_d = !((state_d == WACK) || (state_d == RACK));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      wr_oor_q <= 1'b0;
      rd_oor_q <= 1'b0;
      rdata_q  <= '0;
      wait_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      wr_oor_q <= wr_oor_d;
      rd_oor_q <= rd_oor_d;
      rdata_q  <= rdata_d;
      wait_q   <= wait_d;
    end
  end

`ifdef AVL_RESP_RANGE_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) range_err_q <= 1'b0;
    else       range_err_q <= range_err_d;
  end
`endif

  avl_resp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .BE_WIDTH   (BE_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (IDX_W)
  ) u_ram (
    .clk   (clk),
    .rst   (reset),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (avl_slave_be_mux()),
    .wdata (wdata_q),
    .re    (ram_re),
    .rdata (ram_rdata)
  );

  // With a single cycle of latency the RAM output register is the rdata register;
  // it only updates on read requests, so it already holds between acknowledges.
  assign avl_slave_rdata = (READ_LATENCY == 1) ? (rd_oor_q ? ERR_DATA : ram_rdata) : rdata_q;
  assign avl_slave_waitrequest = wait_q;

  function automatic logic [BE_WIDTH-1:0] avl_slave_be_mux();
    return be_q;
  endfunction

endmodule

// File: tb/tb_avl_mem_responder.sv
// Self-checking bench for avl_mem_responder: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural memory/timing model.
module tb_avl_mem_responder;

  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int BW    = 8;
  localparam int DEPTH = 1024;
  localparam int RL    = 3;

  logic          clk;
  logic          reset;
  logic          cs;
  logic [AW-1:0] addr;
  logic [DW-1:0] rdata;
  logic [DW-1:0] wdata;
  logic [BW-1:0] be;
  logic          wr;
  logic          waitrequest;
`ifdef AVL_RESP_RANGE_CHECK_EN
  logic          range_err;
`endif

  avl_mem_responder #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .BE_WIDTH     (BW),
    .DEPTH        (DEPTH),
    .READ_LATENCY (RL)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .avl_slave_chipselect  (cs),
    .avl_slave_addr        (addr),
    .avl_slave_rdata       (rdata),
    .avl_slave_wdata       (wdata),
    .avl_slave_be          (be),
    .avl_slave_write_req   (wr),
    .avl_slave_waitrequest (waitrequest)
`ifdef AVL_RESP_RANGE_CHECK_EN
    ,
    .range_err             (range_err)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model and scoreboard state
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_rdata;
  logic          exp_wait;
  logic          exp_range_err;

  task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b at %0t", name, got, exp, $time);
  endtask

  function automatic bit is_oor(input logic [63:0] a);
`ifdef AVL_RESP_RANGE_CHECK_EN
    return (a >> 3) >= 64'(DEPTH);
`else
    return (a != a);
`endif
  endfunction

  function automatic int word_idx(input logic [63:0] a);
    logic [63:0] w;
    w = (a >> 3) % 64'(DEPTH);
    return int'(w);
  endfunction

  function automatic logic [63:0] model_read(input logic [63:0] a);
    if (is_oor(a)) return '1;
    return mem_m[word_idx(a)];
  endfunction

  function automatic void model_write(input logic [63:0] a, input logic [63:0] d,
                                      input logic [7:0] b);
    int idx;
    if (is_oor(a)) return;
    idx = word_idx(a);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) mem_m[idx][i*8 +: 8] = d[i*8 +: 8];
    end
  endfunction

  // Compare process: every cycle out of reset
  always @(negedge clk) begin
    if (reset) begin
      last_rdata = '0;
      exp_q.delete();
    end else begin
      if (cs && !wr && !waitrequest) begin
        check_bit("rd_ack_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) last_rdata = exp_q.pop_front();
      end
      check64("rdata", rdata, last_rdata);
      check_bit("waitrequest", waitrequest, exp_wait);
`ifdef AVL_RESP_RANGE_CHECK_EN
      check_bit("range_err", range_err, exp_range_err);
`endif
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request sampled at cycle 0, acknowledged at cycle 1.
  task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] b,
                          input bit abort);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d; be = b; exp_wait = 1'b1;
    tick();
    exp_wait = 1'b0;
    if (is_oor(a)) exp_range_err = 1'b1;
    if (abort) cs = 1'b0;
    else model_write(a, d, b);
    tick();
    cs = 1'b0; exp_wait = 1'b1;
  endtask

  // Request sampled at cycle 0, acknowledged at cycle RL; abort_at in 1..RL-1 drops cs.
  task automatic do_read(input logic [63:0] a, input int abort_at, output logic [63:0] got);
    got = '0;
    cs = 1'b1; wr = 1'b0; addr = a; exp_wait = 1'b1;
    if (abort_at == 0) exp_q.push_back(model_read(a));
    for (int k = 1; k <= RL; k++) begin
      tick();
      if (k == 1 && is_oor(a)) exp_range_err = 1'b1;
      if (k == abort_at) begin
        cs = 1'b0; exp_wait = 1'b1;
        tick();
        return;
      end
      exp_wait = (k == RL) ? 1'b0 : 1'b1;
      if (k == RL) got = rdata;
    end
    tick();
    cs = 1'b0; exp_wait = 1'b1;
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] w;
    w = 64'($urandom_range(0, 15));
    if ($urandom_range(0, 7) == 0) w = w + 64'(DEPTH) * 64'($urandom_range(1, 3));
    return (w << 3) | 64'($urandom_range(0, 7));
  endfunction

  logic [63:0] got;
  logic [63:0] init_val [16];
  int          op;
  logic [63:0] ra;

  initial begin
    reset = 1'b1; cs = 1'b0; wr = 1'b0; addr = '0; wdata = '0; be = '0;
    exp_wait = 1'b1; exp_range_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_bit("reset_waitrequest", waitrequest, 1'b1);
    check64("reset_rdata", rdata, 64'h0);
`ifdef AVL_RESP_RANGE_CHECK_EN
    check_bit("reset_range_err", range_err, 1'b0);
`endif
    reset = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      init_val[i] = {$urandom, $urandom};
      do_write(64'(i) << 3, init_val[i], 8'hFF, 1'b0);
    end

    // Byte-enable merge
    do_write(64'h10, 64'h1122334455667788, 8'hFF, 1'b0);
    do_write(64'h10, 64'hAAAAAAAABBBBBBBB, 8'h0F, 1'b0);
    do_read(64'h10, 0, got);
    check64("be_merge", got, 64'h11223344BBBBBBBB);

    // Master abort in WACK leaves memory alone
    do_write(64'h20, 64'h0123456789ABCDEF, 8'hFF, 1'b0);
    do_write(64'h20, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b1);
    do_read(64'h20, 0, got);
    check64("wr_abort_keeps", got, 64'h0123456789ABCDEF);

    // be=0 is acknowledged with no change
    do_write(64'h20, 64'hDEADBEEFDEADBEEF, 8'h00, 1'b0);
    do_read(64'h20, 0, got);
    check64("be_zero_nochange", got, 64'h0123456789ABCDEF);

    // Back-to-back write then read of the same word
    do_write(64'h38, 64'h5A5A5A5AA5A5A5A5, 8'hFF, 1'b0);
    do_read(64'h38, 0, got);
    check64("wr_then_rd", got, 64'h5A5A5A5AA5A5A5A5);

    // Aborted reads leave rdata untouched
    do_read(64'h10, 1, got);
    do_read(64'h10, 2, got);
    check64("rd_abort_hold", rdata, 64'h5A5A5A5AA5A5A5A5);

    // Reset while a read is pending
    cs = 1'b1; wr = 1'b0; addr = 64'h10; exp_wait = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    check_bit("rst_mid_read_wait", waitrequest, 1'b1);
    check64("rst_mid_read_rdata", rdata, 64'h0);
    cs = 1'b0; exp_range_err = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    do_read(64'h10, 0, got);
    check64("read_after_reset", got, 64'h11223344BBBBBBBB);

    // Word 1024: aliases to word 0, or is rejected with range checking
    do_write(64'h2000, 64'h000000000000CAFE, 8'hFF, 1'b0);
`ifdef AVL_RESP_RANGE_CHECK_EN
    do_read(64'h0, 0, got);
    check64("oor_word0_unchanged", got, init_val[0]);
    do_read(64'h2000, 0, got);
    check64("oor_read_ones", got, 64'hFFFFFFFFFFFFFFFF);
    check_bit("range_err_set", range_err, 1'b1);
`else
    do_read(64'h0, 0, got);
    check64("alias_wrap", got, 64'h000000000000CAFE);
`endif

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 9);
      ra = rand_addr();
      if (op < 4) do_write(ra, {$urandom, $urandom}, 8'($urandom_range(0, 255)), 1'b0);
      else if (op == 4) do_write(ra, {$urandom, $urandom}, 8'($urandom_range(0, 255)), 1'b1);
      else if (op < 9) do_read(ra, 0, got);
      else do_read(ra, $urandom_range(1, RL - 1), got);
      repeat ($urandom_range(0, 2)) tick();
    end

`ifdef AVL_RESP_RANGE_CHECK_EN
    check_bit("range_err_sticky", range_err, 1'b1);
`endif
    tick();
    check_bit("rd_queue_drained", exp_q.size() == 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
